// File: rtl/prbs_pkg.sv
// Shared definitions for the multi-polynomial PRBS generator: mode codes,
// per-mode widths and tap masks, and helpers that map a mode to its masks.
package prbs_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } prbs_state_e;

   localparam logic [2:0] PRBS7  = 3'd0;
   localparam logic [2:0] PRBS9  = 3'd1;
   localparam logic [2:0] PRBS15 = 3'd2;
   localparam logic [2:0] PRBS23 = 3'd3;
   localparam logic [2:0] PRBS31 = 3'd4;

   localparam int W_PRBS7  = 7;
   localparam int W_PRBS9  = 9;
   localparam int W_PRBS15 = 15;
   localparam int W_PRBS23 = 23;
   localparam int W_PRBS31 = 31;

   // One bit per x^k term of the polynomial, excluding the x^N term.
   localparam logic [63:0] M_PRBS7  = 64'h41;
   localparam logic [63:0] M_PRBS9  = 64'h021;
   localparam logic [63:0] M_PRBS15 = 64'h4001;
   localparam logic [63:0] M_PRBS23 = 64'h040001;
   localparam logic [63:0] M_PRBS31 = 64'h10000001;

   function automatic logic [2:0] prbs_norm_mode(input logic [2:0] mode);
      return (mode > PRBS31) ? PRBS31 : mode;
   endfunction

   function automatic logic [63:0] prbs_taps(input logic [2:0] mode);
      logic [63:0] m;
      case (prbs_norm_mode(mode))
         PRBS7:   m = M_PRBS7;
         PRBS9:   m = M_PRBS9;
         PRBS15:  m = M_PRBS15;
         PRBS23:  m = M_PRBS23;
         default: m = M_PRBS31;
      endcase
      return m;
   endfunction

   function automatic logic [63:0] prbs_vmask(input logic [2:0] mode);
      logic [63:0] m;
      case (prbs_norm_mode(mode))
         PRBS7:   m = 64'h7F;
         PRBS9:   m = 64'h1FF;
         PRBS15:  m = 64'h7FFF;
         PRBS23:  m = 64'h7FFFFF;
         default: m = 64'h7FFFFFFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/prbs_lfsr_adv.sv
// Combinational C_DWIDTH-step advance of a Fibonacci shift-right LFSR for the
// selected polynomial; emits the generated bits with the first one at the MSB.
module prbs_lfsr_adv #(
   parameter int C_DWIDTH = 32,
   parameter int C_SWIDTH = 31
) (
   input  logic [C_SWIDTH-1:0] I_state,
   input  logic [2:0]          I_mode,
   output logic [C_SWIDTH-1:0] O_state,
   output logic [C_DWIDTH-1:0] O_word
);
   import prbs_pkg::*;

   logic [C_SWIDTH-1:0] taps;
   logic [C_SWIDTH-1:0] vmask;
   logic [C_SWIDTH-1:0] top;
   logic [C_SWIDTH-1:0] s;
   logic                fb;

   always_comb begin
      taps   = C_SWIDTH'(prbs_taps(I_mode));
      vmask  = C_SWIDTH'(prbs_vmask(I_mode));
      // Single bit at position N-1, where feedback re-enters the register.
      top    = vmask ^ (vmask >> 1);
      s      = I_state & vmask;
      fb     = 1'b0;
      O_word = '0;
      for (int i = 0; i < C_DWIDTH; i++) begin
         O_word[C_DWIDTH-1-i] = s[0];
         fb = ^(s & taps);
         s  = (s >> 1) | (fb ? top : '0);
      end
      O_state = s;
   end

endmodule

// File: rtl/prbs_gen_mp.sv
// Run-time selectable PRBS7/9/15/23/31 generator with a ready/valid output,
// seed load with zero-seed guard and single-bit error injection.
// Optional PRBS_GEN_MP_INV_EN adds I_inv for inverted-pattern output.
module prbs_gen_mp #(
   parameter int C_DWIDTH = 32,
   parameter int C_SWIDTH = 31,
   parameter int C_CNT_W  = 16
) (
   input  logic                I_clk,
   input  logic                I_rst_n,
   input  logic [2:0]          I_mode,
   input  logic [C_SWIDTH-1:0] I_init,
   input  logic                I_init_v,
   input  logic                I_en,
   input  logic                I_inj,
`ifdef PRBS_GEN_MP_INV_EN
   input  logic                I_inv,
`endif
   input  logic                I_ready,
   output logic [C_DWIDTH-1:0] O_prbs,
   output logic                O_prbs_v,
   output logic                O_run,
   output logic [C_CNT_W-1:0]  O_inj_cnt
);
   import prbs_pkg::*;

   prbs_state_e         state_q, state_d;
   logic [2:0]          mode_q, mode_d;
   logic [C_SWIDTH-1:0] lfsr_q, lfsr_d;
   logic [C_DWIDTH-1:0] prbs_q, prbs_d;
   logic                prbs_v_q, prbs_v_d;
   logic                inj_pend_q, inj_pend_d;
   logic [C_CNT_W-1:0]  inj_cnt_q, inj_cnt_d;

   logic [2:0]          new_mode;
   logic [2:0]          src_mode;
   logic [C_SWIDTH-1:0] new_vmask;
   logic [C_SWIDTH-1:0] seed_m;
   logic [C_SWIDTH-1:0] seed_state;
   logic [C_SWIDTH-1:0] src_state;
   logic [C_SWIDTH-1:0] adv_state;
   logic [C_DWIDTH-1:0] adv_word;
   logic [C_DWIDTH-1:0] inv_mask;
   logic [C_DWIDTH-1:0] inj_mask;
   logic                adv;
   logic                inj_req;

   prbs_lfsr_adv #(
      .C_DWIDTH (C_DWIDTH),
      .C_SWIDTH (C_SWIDTH)
   ) u_adv (
      .I_state (src_state),
      .I_mode  (src_mode),
      .O_state (adv_state),
      .O_word  (adv_word)
   );

   always_comb begin
      new_mode   = prbs_norm_mode(I_mode);
      new_vmask  = C_SWIDTH'(prbs_vmask(new_mode));
      seed_m     = I_init & new_vmask;
      seed_state = (seed_m == '0) ? new_vmask : seed_m;
      // A seed arriving with an advance is used for that very word.
      src_state  = I_init_v ? seed_state : lfsr_q;
      src_mode   = I_init_v ? new_mode : mode_q;

      adv     = I_en & ((state_q == ST_RUN) | I_init_v) & (~prbs_v_q | I_ready);
      inj_req = inj_pend_q | I_inj;
`ifdef PRBS_GEN_MP_INV_EN
      inv_mask = {C_DWIDTH{I_inv}};
`else
      inv_mask = '0;
`endif
      inj_mask = C_DWIDTH'(inj_req);

      state_d    = I_init_v ? ST_RUN : state_q;
      mode_d     = I_init_v ? new_mode : mode_q;
      lfsr_d     = lfsr_q;
      prbs_d     = prbs_q;
      prbs_v_d   = prbs_v_q;
      inj_pend_d = inj_req;
      inj_cnt_d  = inj_cnt_q;

      if (adv) begin
         lfsr_d     = adv_state;
         prbs_d     = (adv_word ^ inv_mask) ^ inj_mask;
         prbs_v_d   = 1'b1;
         inj_pend_d = 1'b0;
         if (inj_req && !(&inj_cnt_q))
            inj_cnt_d = inj_cnt_q + 1'b1;
      end else begin
         if (I_init_v)
            lfsr_d = seed_state;
         if (I_ready)
            prbs_v_d = 1'b0;
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q    <= ST_IDLE;
         mode_q     <= PRBS31;
         lfsr_q     <= '0;
         prbs_q     <= '0;
         prbs_v_q   <= 1'b0;
         inj_pend_q <= 1'b0;
         inj_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         lfsr_q     <= lfsr_d;
         prbs_q     <= prbs_d;
         prbs_v_q   <= prbs_v_d;
         inj_pend_q <= inj_pend_d;
         inj_cnt_q  <= inj_cnt_d;
      end
   end

   assign O_prbs    = prbs_q;
   assign O_prbs_v  = prbs_v_q;
   assign O_run     = (state_q == ST_RUN);
   assign O_inj_cnt = inj_cnt_q;

endmodule

// File: doc/prbs_gen_mp.md
Name: prbs_gen_mp

Overview:
- Multi-polynomial parallel PRBS generator. Next generation of the single-fixed-polynomial PRBS generator.
- Polynomial is selectable at run time (PRBS7/9/15/23/31).
- Output is a registered ready/valid stream with backpressure. Adds seed load with zero-seed guard, single-bit error injection and an injection counter.
- Feeds link/serdes test datapaths and pairs with the PRBS checker on the receive side.

Parameters:
- C_DWIDTH, 32, output word width in bits (1..64). Bits per advance.
- C_SWIDTH, 31, LFSR register width. Must be >= 31 so all modes fit.
- C_CNT_W, 16, width of the saturating injection counter.

Ports:
- I_clk  in  1  clock.
- I_rst_n  in  1  asynchronous active-low reset.
- I_mode  in  3  polynomial select: 0=PRBS7, 1=PRBS9, 2=PRBS15, 3=PRBS23, 4=PRBS31. Values 5-7 are treated as PRBS31.
- I_init  in  C_SWIDTH  seed. Only the low N bits are used for an N-bit mode.
- I_init_v  in  1  load seed and mode.
- I_en  in  1  generation enable.
- I_inj  in  1  single-cycle error-injection request.
- I_ready  in  1  downstream ready.
- O_prbs  out  C_DWIDTH  PRBS word. First-generated bit is at the MSB.
- O_prbs_v  out  1  word valid.
- O_run  out  1  FSM is in RUN.
- O_inj_cnt  out  C_CNT_W  injections emitted.

Behaviour:
- LFSR (Fibonacci, shift-right), N = mode width, M = tap mask:
  - Per step: out bit = S[0]; S[N-1:0] <= {^(S[N-1:0] & M), S[N-1:1]}; bits above N-1 are held at 0.
  - M has bit k set for each x^k term except x^N:
    - PRBS7 x^7+x^6+1 -> 0x41
    - PRBS9 x^9+x^5+1 -> 0x021
    - PRBS15 x^15+x^14+1 -> 0x4001
    - PRBS23 x^23+x^18+1 -> 0x040001
    - PRBS31 x^31+x^28+1 -> 0x10000001
  - One word = C_DWIDTH steps, all computed combinationally within one cycle.
- Reset (async assert, sync deassert handled externally):
  - O_prbs=0, O_prbs_v=0, O_run=0, O_inj_cnt=0.
  - LFSR=0, mode register=PRBS31, FSM=IDLE, inject-pending=0.
- FSM:
  - IDLE -> RUN on I_init_v.
  - RUN -> RUN on I_init_v (reseed).
  - No other transitions. Only reset returns the FSM to IDLE.
- Seed load on I_init_v:
  - Mode register <= I_mode.
  - Source state = I_init masked to N bits. If the masked seed is 0, all N low bits are set to 1 (zero-seed guard).
- Advance condition: adv = I_en & (RUN or I_init_v) & (!O_prbs_v | I_ready).
  - If I_init_v coincides with adv, the word is generated from the new seed, so the first bit is the seed's bit0.
  - If I_init_v arrives without adv, the seed and mode are stored, no word is produced, and any pending output word is kept unchanged.
- On adv:
  - O_prbs <= word from source state.
  - LFSR <= source state advanced C_DWIDTH steps.
  - O_prbs_v <= 1.
- Valid drop: when !adv & I_ready & O_prbs_v, O_prbs_v <= 0.
- Backpressure:
  - While O_prbs_v=1 and I_ready=0, O_prbs is held stable and the LFSR does not advance.
  - No bits are lost or duplicated.
- Latency: 1 cycle from adv to valid data.
- Error injection:
  - I_inj sets inject-pending. Requests arriving while pending is already set are merged, not counted twice.
  - The next adv word has bit0 (LSB) inverted in O_prbs only; the LFSR is unaffected.
  - Pending clears on that adv. O_inj_cnt increments by 1 and saturates at all-ones.
  - I_inj in the same cycle as adv applies to that same word.
- Mode change takes effect only via I_init_v. I_mode is ignored otherwise.

Optional Feature:
- Macro: PRBS_GEN_MP_INV_EN.
- Defined:
  - Adds input I_inv (1 bit), sampled on adv.
  - When I_inv=1, the emitted word is bitwise inverted (ITU inverted PRBS). Injection is applied after inversion.
- Undefined: the port is absent and the output is never inverted.

Decomposition:
- Package prbs_pkg holds:
  - mode encodings (PRBS7..PRBS31 localparams)
  - per-mode width N and tap mask M constants
  - function returning the N-bit valid-mask for a mode
- One sub-module, prbs_lfsr_adv (parameter C_DWIDTH, C_SWIDTH), purely combinational:
  - inputs: state, mode
  - outputs: next state, output word
- prbs_gen_mp holds the FSM, output register, handshake and injection logic.

Test Plan:
- C_DWIDTH=8, PRBS7, seed 7'h7F, I_en=1, I_ready=1 -> first O_prbs=8'hFE one cycle after I_init_v. Word 127 equals word 0 (period 127).
- PRBS7, seed 0 -> zero guard loads 7'h7F -> first word 8'hFE. The LFSR never reaches 0 over 1000 words.
- I_ready low for 3 cycles mid-stream -> O_prbs and O_prbs_v held. The stream after release is bit-exact with a reference model fed with no stalls.
- I_inj pulse -> exactly the next word equals the model word XOR 8'h01. O_inj_cnt=1. Following words match the model. Two pulses before one adv -> O_inj_cnt=1.
- Reseed to PRBS31 with seed 31'h1 mid-run -> the next word is generated from the new seed. Output matches the PRBS31 model. Checked for C_DWIDTH=32 and 64.
- I_rst_n asserted mid-stream (asynchronous to I_clk) -> O_prbs_v=0, O_run=0, O_inj_cnt=0 immediately. No valid output until the next I_init_v.
